// File: rtl/branch_predict_pc_unit_pkg.sv
// Shared definitions for the fetch PC / branch prediction unit: opcodes,
// condition codes, flag positions and the BTB saturating counter type.
package branch_predict_pc_unit_pkg;

   localparam logic [3:0] OP_B  = 4'hC;
   localparam logic [3:0] OP_BR = 4'hD;

   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_N = 0;

   localparam int unsigned CTR_W = 2;
   typedef logic [CTR_W-1:0] ctr_t;

   localparam ctr_t CTR_MAX   = 2'd3;
   localparam ctr_t CTR_ALLOC = 2'd2;
   localparam ctr_t CTR_TAKEN = 2'd2;

   typedef enum logic [2:0] {
      CC_NE = 3'b000,
      CC_EQ = 3'b001,
      CC_GT = 3'b010,
      CC_LT = 3'b011,
      CC_GE = 3'b100,
      CC_LE = 3'b101,
      CC_VS = 3'b110,
      CC_AL = 3'b111
   } cond_e;

   // Evaluate a branch condition against the {Z,V,N} flag vector.
   function automatic logic cond_eval(input cond_e cc, input logic [2:0] flags);
      logic z, v, n, r;
      z = flags[FLAG_Z];
      v = flags[FLAG_V];
      n = flags[FLAG_N];
      r = 1'b0;
      case (cc)
         CC_NE:   r = !z;
         CC_EQ:   r = z;
         CC_GT:   r = !z && !n;
         CC_LT:   r = n;
         CC_GE:   r = z || (!z && !n);
         CC_LE:   r = n || z;
         CC_VS:   r = v;
         CC_AL:   r = 1'b1;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB on halfword-aligned addresses: combinational lookup,
// synchronous update with 2-bit saturating direction counters.
module branch_target_buffer
   import branch_predict_pc_unit_pkg::*;
#(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned ENTRIES = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-2:0] rd_wa_i,
   output logic              rd_taken_o,
   output logic [ADDR_W-1:0] rd_target_o,
   input  logic              wr_en_i,
   input  logic [ADDR_W-2:0] wr_wa_i,
   input  logic              wr_taken_i,
   input  logic [ADDR_W-1:0] wr_target_i
);

   localparam int unsigned WA_W  = ADDR_W - 1;
   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned TAG_W = WA_W - IDX_W;

   logic              valid_q [ENTRIES];
   logic [TAG_W-1:0]  tag_q   [ENTRIES];
   logic [ADDR_W-1:0] tgt_q   [ENTRIES];
   ctr_t              ctr_q   [ENTRIES];

   logic [IDX_W-1:0] rd_idx, wr_idx;
   logic [TAG_W-1:0] rd_tag, wr_tag;
   logic             wr_hit;
   ctr_t             ctr_upd;

   assign rd_idx = rd_wa_i[IDX_W-1:0];
   assign rd_tag = rd_wa_i[WA_W-1:IDX_W];
   assign wr_idx = wr_wa_i[IDX_W-1:0];
   assign wr_tag = wr_wa_i[WA_W-1:IDX_W];

   // Lookup reads pre-update contents even when the write hits the same index.
   assign rd_taken_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag)
                        && (ctr_q[rd_idx] >= CTR_TAKEN);
   assign rd_target_o = tgt_q[rd_idx];

   assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

   always_comb begin
      ctr_upd = ctr_q[wr_idx];
      if (wr_taken_i) begin
         if (ctr_q[wr_idx] != CTR_MAX) ctr_upd = ctr_q[wr_idx] + ctr_t'(1);
      end else begin
         if (ctr_q[wr_idx] != ctr_t'(0)) ctr_upd = ctr_q[wr_idx] - ctr_t'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(ENTRIES); i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= '0;
         end
      end else if (wr_en_i) begin
         if (wr_hit) begin
            ctr_q[wr_idx] <= ctr_upd;
            if (wr_taken_i) tgt_q[wr_idx] <= wr_target_i;
         end else if (wr_taken_i) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            tgt_q[wr_idx]   <= wr_target_i;
            ctr_q[wr_idx]   <= CTR_ALLOC;
         end
      end
   end

endmodule

// File: rtl/branch_predict_pc_unit.sv
// Fetch PC generator: resolves branches from execute, redirects on
// mispredict, follows BTB predictions and handles stall/halt.
module branch_predict_pc_unit
   import branch_predict_pc_unit_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 16,
   parameter int unsigned       BTB_ENTRIES = 8,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              halt_in,
   input  logic              ex_valid,
   input  logic [3:0]        ex_opcode,
   input  logic [2:0]        ex_cond,
   input  logic [8:0]        ex_imm,
   input  logic [2:0]        ex_flags,
   input  logic [ADDR_W-1:0] ex_pc,
   input  logic [ADDR_W-1:0] ex_rs_data,
   input  logic              ex_pred_taken,
   input  logic [ADDR_W-1:0] ex_pred_target,
   output logic [ADDR_W-1:0] fetch_pc,
   output logic              fetch_valid,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   output logic              flush,
   output logic              halted
);

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              halted_q, halted_d;

   logic              resolved, actual_taken, mispredict;
   logic [ADDR_W-1:0] imm_ext, fall_thru, br_target, redirect_pc;
   logic              btb_taken;
   logic [ADDR_W-1:0] btb_target;

   assign resolved     = ex_valid && ((ex_opcode == OP_B) || (ex_opcode == OP_BR));
   assign actual_taken = cond_eval(cond_e'(ex_cond), ex_flags);

   // Word offset: sign-extend then scale to bytes; wrap-around is intended.
   assign imm_ext     = ADDR_W'($signed(ex_imm));
   assign fall_thru   = ex_pc + ADDR_W'(2);
   assign br_target   = (ex_opcode == OP_BR) ? ex_rs_data : fall_thru + (imm_ext << 1);
   assign redirect_pc = actual_taken ? br_target : fall_thru;

   assign mispredict = resolved && ((actual_taken != ex_pred_taken)
                       || (actual_taken && ex_pred_taken && (br_target != ex_pred_target)));

   branch_target_buffer #(
      .ADDR_W  (ADDR_W),
      .ENTRIES (BTB_ENTRIES)
   ) u_btb (
      .clk         (clk),
      .rst_n       (rst_n),
      .rd_wa_i     (pc_q[ADDR_W-1:1]),
      .rd_taken_o  (btb_taken),
      .rd_target_o (btb_target),
      .wr_en_i     (resolved),
      .wr_wa_i     (ex_pc[ADDR_W-1:1]),
      .wr_taken_i  (actual_taken),
      .wr_target_i (br_target)
   );

   // Redirect wins over halt/stall; a halt_in on the squashed path is dropped.
   always_comb begin
      pc_d     = pc_q + ADDR_W'(2);
      halted_d = halted_q;
      if (mispredict) begin
         pc_d = redirect_pc;
      end else if (halted_q || halt_in) begin
         pc_d     = pc_q;
         halted_d = 1'b1;
      end else if (stall) begin
         pc_d = pc_q;
      end else if (btb_taken) begin
         pc_d = btb_target;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
      end else begin
         pc_q     <= pc_d;
         halted_q <= halted_d;
      end
   end

   assign fetch_pc    = pc_q;
   assign fetch_valid = !halted_q;
   assign halted      = halted_q;
   assign pred_taken  = rst_n && btb_taken;
   assign pred_target = btb_target;
   assign flush       = rst_n && mispredict;

endmodule

// File: tb/tb_branch_predict_pc_unit.sv
// Table-driven scoreboard bench for branch_predict_pc_unit (default parameters).
module tb_branch_predict_pc_unit;

   typedef struct {
      logic        rst_n, stall, halt, exv;
      logic [3:0]  op;
      logic [2:0]  cond;
      logic [8:0]  imm;
      logic [2:0]  flags;
      logic [15:0] expc, rs;
      logic        ptk;
      logic [15:0] ptgt;
      logic [15:0] e_pc;
      logic        e_ptk;
      logic [15:0] e_ptgt;
      logic        e_flush, e_halted;
   } vec_t;

   typedef struct {
      int          idx;
      logic [15:0] pc;
      logic        ptk;
      logic [15:0] ptgt;
      logic        flush, halted;
   } exp_t;

   logic        clk, rst_n, stall, halt_in, ex_valid, ex_pred_taken;
   logic [3:0]  ex_opcode;
   logic [2:0]  ex_cond, ex_flags;
   logic [8:0]  ex_imm;
   logic [15:0] ex_pc, ex_rs_data, ex_pred_target;
   logic [15:0] fetch_pc, pred_target;
   logic        fetch_valid, pred_taken, flush, halted;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];
   vec_t tv[$];
   exp_t cur;

   branch_predict_pc_unit #(
      .ADDR_W      (16),
      .BTB_ENTRIES (8),
      .RESET_PC    (16'h0000)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall          (stall),
      .halt_in        (halt_in),
      .ex_valid       (ex_valid),
      .ex_opcode      (ex_opcode),
      .ex_cond        (ex_cond),
      .ex_imm         (ex_imm),
      .ex_flags       (ex_flags),
      .ex_pc          (ex_pc),
      .ex_rs_data     (ex_rs_data),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .fetch_pc       (fetch_pc),
      .fetch_valid    (fetch_valid),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .flush          (flush),
      .halted         (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t v(
      input logic r, s, h, x, input logic [3:0] op, input logic [2:0] c,
      input logic [8:0] im, input logic [2:0] f, input logic [15:0] pc, rs,
      input logic pt, input logic [15:0] pg, input logic [15:0] e_pc,
      input logic e_pt, input logic [15:0] e_pg, input logic e_fl, e_hl);
      vec_t t;
      t.rst_n = r;  t.stall = s;  t.halt = h;  t.exv = x;
      t.op = op;  t.cond = c;  t.imm = im;  t.flags = f;
      t.expc = pc;  t.rs = rs;  t.ptk = pt;  t.ptgt = pg;
      t.e_pc = e_pc;  t.e_ptk = e_pt;  t.e_ptgt = e_pg;
      t.e_flush = e_fl;  t.e_halted = e_hl;
      return t;
   endfunction

   function automatic vec_t idle(input logic s, input logic [15:0] e_pc,
                                 input logic e_pt, input logic [15:0] e_pg, input logic e_hl);
      return v(1, s, 0, 0, 4'h0, 3'b000, 9'h000, 3'b000, 16'h0, 16'h0, 0, 16'h0,
               e_pc, e_pt, e_pg, 0, e_hl);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @vec %0d: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic apply(input vec_t t, input int idx);
      exp_t e;
      rst_n = t.rst_n;  stall = t.stall;  halt_in = t.halt;  ex_valid = t.exv;
      ex_opcode = t.op;  ex_cond = t.cond;  ex_imm = t.imm;  ex_flags = t.flags;
      ex_pc = t.expc;  ex_rs_data = t.rs;  ex_pred_taken = t.ptk;  ex_pred_target = t.ptgt;
      e.idx = idx;  e.pc = t.e_pc;  e.ptk = t.e_ptk;  e.ptgt = t.e_ptgt;
      e.flush = t.e_flush;  e.halted = t.e_halted;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Compare combinational/registered outputs mid-cycle against the scoreboard.
   always @(negedge clk) begin
      if (sb.size() != 0) begin
         cur = sb.pop_front();
         chk("fetch_pc", cur.idx, fetch_pc, cur.pc);
         chk("pred_taken", cur.idx, 16'(pred_taken), 16'(cur.ptk));
         if (cur.ptk) chk("pred_target", cur.idx, pred_target, cur.ptgt);
         chk("flush", cur.idx, 16'(flush), 16'(cur.flush));
         chk("halted", cur.idx, 16'(halted), 16'(cur.halted));
         chk("fetch_valid", cur.idx, 16'(fetch_valid), 16'(!cur.halted));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0;  stall = 0;  halt_in = 0;  ex_valid = 0;  ex_opcode = 0;
      ex_cond = 0;  ex_imm = 0;  ex_flags = 0;  ex_pc = 0;  ex_rs_data = 0;
      ex_pred_taken = 0;  ex_pred_target = 0;
      @(posedge clk);
      #1;

      // reset gates a would-be mispredict
      tv.push_back(v(0,0,0,1,4'hC,3'b111,9'h000,3'b000,16'h0010,16'h0,0,16'h0, 16'h0000,0,16'h0,0,0));
      tv.push_back(idle(0,16'h0000,0,16'h0,0));
      tv.push_back(idle(0,16'h0002,0,16'h0,0));
      tv.push_back(idle(0,16'h0004,0,16'h0,0));
      // B backward taken, allocate; then train down with not-taken
      tv.push_back(v(1,0,0,1,4'hC,3'b001,9'h1FE,3'b100,16'h0010,16'h0,0,16'h0, 16'h0006,0,16'h0,1,0));
      tv.push_back(idle(0,16'h000E,0,16'h0,0));
      tv.push_back(v(1,0,0,1,4'hC,3'b001,9'h1FE,3'b000,16'h0010,16'h0,0,16'h0, 16'h0010,1,16'h000E,0,0));
      tv.push_back(idle(0,16'h000E,0,16'h0,0));
      tv.push_back(v(1,0,0,1,4'hC,3'b001,9'h1FE,3'b000,16'h0010,16'h0,0,16'h0, 16'h0010,0,16'h0,0,0));
      tv.push_back(v(1,0,0,1,4'hC,3'b111,9'h1FE,3'b000,16'h0010,16'h0,0,16'h0, 16'h0012,0,16'h0,1,0));
      tv.push_back(idle(0,16'h000E,0,16'h0,0));
      tv.push_back(idle(0,16'h0010,0,16'h0,0));
      // BR wrong target
      tv.push_back(v(1,0,0,1,4'hD,3'b111,9'h000,3'b000,16'h0020,16'h1234,1,16'h1000, 16'h0012,0,16'h0,1,0));
      tv.push_back(idle(0,16'h1234,0,16'h0,0));
      // halt with stall, redirect while halted
      tv.push_back(v(1,1,1,0,4'h0,3'b000,9'h000,3'b000,16'h0,16'h0,0,16'h0, 16'h1236,0,16'h0,0,0));
      tv.push_back(idle(0,16'h1236,0,16'h0,1));
      tv.push_back(v(1,0,0,1,4'hC,3'b111,9'h004,3'b000,16'h0040,16'h0,0,16'h0, 16'h1236,0,16'h0,1,1));
      tv.push_back(idle(0,16'h004A,0,16'h0,1));
      tv.push_back(idle(0,16'h004A,0,16'h0,1));
      // wrap-around target: correct prediction then wrong one
      tv.push_back(v(1,0,0,1,4'hC,3'b111,9'h001,3'b000,16'hFFFE,16'h0,1,16'h0002, 16'h004A,0,16'h0,0,1));
      tv.push_back(v(1,0,0,1,4'hC,3'b111,9'h001,3'b000,16'hFFFE,16'h0,1,16'h0000, 16'h004A,0,16'h0,1,1));
      tv.push_back(idle(0,16'h0002,0,16'h0,1));
      tv.push_back(v(0,0,0,0,4'h0,3'b000,9'h000,3'b000,16'h0,16'h0,0,16'h0, 16'h0002,0,16'h0,0,1));
      // halt_in coincident with flush is ignored
      tv.push_back(v(1,0,1,1,4'hC,3'b111,9'h000,3'b000,16'h0100,16'h0,0,16'h0, 16'h0000,0,16'h0,1,0));
      tv.push_back(idle(0,16'h0102,0,16'h0,0));
      tv.push_back(idle(1,16'h0104,0,16'h0,0));
      tv.push_back(v(1,1,0,1,4'hD,3'b111,9'h000,3'b000,16'h0200,16'h0300,0,16'h0, 16'h0104,0,16'h0,1,0));
      tv.push_back(idle(0,16'h0300,0,16'h0,0));
      // invalid branch and non-branch opcode never flush
      tv.push_back(v(1,0,0,0,4'hC,3'b111,9'h000,3'b000,16'h0000,16'h0,0,16'h0, 16'h0302,0,16'h0,0,0));
      tv.push_back(v(1,0,0,1,4'h3,3'b111,9'h000,3'b000,16'h0000,16'h0,0,16'h0, 16'h0304,0,16'h0,0,0));
      // remaining condition codes
      tv.push_back(v(1,0,0,1,4'hC,3'b011,9'h000,3'b001,16'h0500,16'h0,0,16'h0, 16'h0306,0,16'h0,1,0));
      tv.push_back(v(1,0,0,1,4'hC,3'b110,9'h000,3'b010,16'h0600,16'h0,1,16'h0602, 16'h0502,0,16'h0,0,0));
      tv.push_back(v(1,0,0,1,4'hC,3'b101,9'h000,3'b000,16'h0700,16'h0,1,16'h0000, 16'h0504,0,16'h0,1,0));
      tv.push_back(v(1,0,0,1,4'hC,3'b100,9'h000,3'b100,16'h0800,16'h0,0,16'h0, 16'h0702,0,16'h0,1,0));
      tv.push_back(v(1,0,0,1,4'hC,3'b000,9'h000,3'b100,16'h0900,16'h0,0,16'h0, 16'h0802,0,16'h0,0,0));
      tv.push_back(v(1,0,0,1,4'hC,3'b010,9'h000,3'b000,16'h0A00,16'h0,0,16'h0, 16'h0804,0,16'h0,1,0));
      tv.push_back(idle(0,16'h0A02,0,16'h0,0));

      foreach (tv[i]) apply(tv[i], i);

      // Hand sequence: train a short loop, then stall over a predicted-taken PC.
      apply(v(1,0,0,1,4'hC,3'b111,9'h1FD,3'b000,16'h0A06,16'h0,0,16'h0, 16'h0A04,0,16'h0,1,0), 100);
      apply(idle(0,16'h0A02,0,16'h0,0), 101);
      apply(idle(0,16'h0A04,0,16'h0,0), 102);
      apply(idle(1,16'h0A06,1,16'h0A02,0), 103);
      apply(idle(1,16'h0A06,1,16'h0A02,0), 104);
      apply(idle(0,16'h0A06,1,16'h0A02,0), 105);
      apply(idle(0,16'h0A02,0,16'h0,0), 106);

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
